id_stage: RTL and testbench
===========================

# id_stage

Pipelined, parametrised instruction-decode stage. Accepts fetched instructions with their PC over a valid/ready handshake, decodes the RV32 fields into type, register indices, funct fields and a sign-extended immediate, and presents the result through a 2-entry skid buffer to the execute stage. Sits between fetch and execute and supports flush on redirect.

## Interface
- INSTRUCTION_WIDTH, 32, instruction word width; must be 32.
- XLEN, 32, immediate output width; must be ≥ 32. Immediates are sign-extended from bit 31 of the instruction.
- PC_WIDTH, 32, width of the PC carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept; equals NOT skid_valid (registered).
- in_instruction  in  INSTRUCTION_WIDTH  instruction word.
- in_pc  in  PC_WIDTH  PC of the instruction.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_WIDTH  PC of the presented entry.
- out_opcode  out  7  instruction[6:0].
- out_type  out  3  instr_type_e: R=0, I=1, S=2, B=3, U=4, J=5, NONE=6.
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when the type has no such field.
- out_funct3  out  3  0 for U/J/NONE.
- out_funct7  out  7  R-type only, else 0.
- out_imm  out  XLEN  sign-extended immediate; 0 for R/NONE.
- out_illegal  out  1  entry is an illegal encoding (see Configuration).

## Operation
- Opcode map: 0110011 and 0101111 → R; 0010011, 0000011, 1100111 and 1110011 → I; 0100011 → S; 1100011 → B; 0110111 and 0010111 → U; 1101111 → J; anything else → NONE.
- Immediates:
  - I: sx(inst[31:20]).
  - S: sx({inst[31:25], inst[11:7]}).
  - B: sx({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: sx({inst[31:12], 12'b0}).
  - J: sx({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Sign extension replicates inst[31] up to XLEN-1.
- Decode is combinational on the input side. Its result plus the PC is written into the buffer.
- Buffer holds two entries: main (drives the outputs) and skid.
  - Accept = in_valid & in_ready.
  - main empty, or main being consumed (out_valid & out_ready): the accepted entry goes to main (or to main from skid if skid is full; see below).
  - main full and not consumed: the accepted entry goes to skid.
  - On consume with skid full: skid moves to main and skid clears. in_ready is 0 that cycle, so there is no simultaneous accept.
- Order is strict FIFO. No entry is lost or duplicated.
- flush has priority over everything. On the next edge both entries are invalidated and any accept in the flush cycle is discarded.
- Reset (also mid-operation) behaves the same as flush and additionally zeroes all data registers.

## Timing
- Reset values:
  - out_valid = 0.
  - in_ready = 1.
  - All data outputs = 0.
  - out_type = NONE(6).
  - out_illegal = 0.
- Latency is 1 cycle: an instruction accepted at edge N is visible on outputs after edge N, provided main is free.
- Throughput is 1 instruction per cycle while out_ready is held high.
- Outputs are stable while out_valid & !out_ready.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- After a stall ends (out_ready rises with both entries full), in_ready returns to 1 one cycle later.

## Configuration
- Macro ID_STAGE_ILLEGAL_CHECK_EN.
  - Defined: out_illegal = 1 when any of the following holds:
    - out_type is NONE;
    - inst[1:0] ≠ 2'b11;
    - opcode is 0110011 with funct7 ∉ {0000000, 0100000, 0000001}.
  - Illegal entries still flow through the buffer with their decoded fields.
  - Not defined: out_illegal is tied to 0 and the check logic is absent. NONE entries still pass with zeroed fields.

## Structure
- Package id_pkg holds:
  - instr_type_e;
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_AMO);
  - the packed struct decoded_t that forms a buffer entry.
- Sub-module id_decode: purely combinational, maps instruction to decoded_t. id_stage instantiates it and owns the skid buffer.

## Test plan
- 0xFFF10093 (addi x1,x2,-1), out_ready=1 → next cycle: out_valid=1, type=I, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF.
- 0xFE000EE3 (beq x0,x0,-4) → type=B, rs1=rs2=0, imm=0xFFFFFFFC, rd=0.
- 0x123452B7 (lui x5,0x12345) then 0x0000006F (jal x0,0) back-to-back → consecutive cycles:
  - first: type=U, rd=5, imm=0x12345000;
  - second: type=J, imm=0.
- in_valid=1 with PCs 0x0, 0x4, 0x8, …; out_ready=0 for 3 cycles → exactly two entries accepted, then in_ready=0. After out_ready=1, outputs PC 0x0, 0x4, 0x8 in order with none missing.
- Both entries full, flush=1 for one cycle → next cycle out_valid=0 and in_ready=1. The instruction offered during the flush cycle never appears.
- 0x00000000 → type=NONE, imm=0; out_illegal=1 with ID_STAGE_ILLEGAL_CHECK_EN, 0 without. rst_n=0 mid-stream → next cycle out_valid=0 and all data outputs 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode types for the instruction-decode stage: instruction classes,
// RV32 opcode values and the decoded entry held in the stage's buffer.
package id_pkg;

    typedef enum logic [2:0] {
        T_R    = 3'd0,
        T_I    = 3'd1,
        T_S    = 3'd2,
        T_B    = 3'd3,
        T_U    = 3'd4,
        T_J    = 3'd5,
        T_NONE = 3'd6
    } instr_type_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    // Immediate is kept at 32 bits; the top sign-extends it to XLEN.
    typedef struct packed {
        logic [6:0]  opcode;
        instr_type_e itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    localparam decoded_t DECODED_RESET = '{
        opcode: 7'd0, itype: T_NONE, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
        funct3: 3'd0, funct7: 7'd0, imm: 32'd0, illegal: 1'b0
    };

endpackage

// File: rtl/id_decode.sv
// Combinational RV32 field decoder. Illegal-encoding detection is built only
// when ID_STAGE_ILLEGAL_CHECK_EN is defined; otherwise illegal is tied low.
module id_decode
    import id_pkg::*;
(
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    always_comb begin
        dec_o        = DECODED_RESET;
        dec_o.opcode = instr_i[6:0];

        case (instr_i[6:0])
            OP_R, OP_AMO:                        dec_o.itype = T_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: dec_o.itype = T_I;
            OP_STORE:                            dec_o.itype = T_S;
            OP_BRANCH:                           dec_o.itype = T_B;
            OP_LUI, OP_AUIPC:                    dec_o.itype = T_U;
            OP_JAL:                              dec_o.itype = T_J;
            default:                             dec_o.itype = T_NONE;
        endcase

        // Fields a format lacks stay at their zero default.
        case (dec_o.itype)
            T_R: begin
                dec_o.rd     = instr_i[11:7];
                dec_o.rs1    = instr_i[19:15];
                dec_o.rs2    = instr_i[24:20];
                dec_o.funct3 = instr_i[14:12];
                dec_o.funct7 = instr_i[31:25];
            end
            T_I: begin
                dec_o.rd     = instr_i[11:7];
                dec_o.rs1    = instr_i[19:15];
                dec_o.funct3 = instr_i[14:12];
                dec_o.imm    = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            T_S: begin
                dec_o.rs1    = instr_i[19:15];
                dec_o.rs2    = instr_i[24:20];
                dec_o.funct3 = instr_i[14:12];
                dec_o.imm    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            T_B: begin
                dec_o.rs1    = instr_i[19:15];
                dec_o.rs2    = instr_i[24:20];
                dec_o.funct3 = instr_i[14:12];
                dec_o.imm    = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            end
            T_U: begin
                dec_o.rd     = instr_i[11:7];
                dec_o.imm    = {instr_i[31:12], 12'd0};
            end
            T_J: begin
                dec_o.rd     = instr_i[11:7];
                dec_o.imm    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            end
            default: ;
        endcase

`ifdef ID_STAGE_ILLEGAL_CHECK_EN
        dec_o.illegal = (dec_o.itype == T_NONE) || (instr_i[1:0] != 2'b11) ||
                        ((instr_i[6:0] == OP_R) &&
                         !(instr_i[31:25] inside {7'b0000000, 7'b0100000, 7'b0000001}));
`else
        dec_o.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage with a 2-entry skid buffer between fetch and execute.
// Optional illegal-encoding flag: define ID_STAGE_ILLEGAL_CHECK_EN.
module id_stage
    import id_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int XLEN              = 32,
    parameter int PC_WIDTH          = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instruction,
    input  logic [PC_WIDTH-1:0]          in_pc,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [6:0]                   out_opcode,
    output logic [2:0]                   out_type,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [2:0]                   out_funct3,
    output logic [6:0]                   out_funct7,
    output logic [XLEN-1:0]              out_imm,
    output logic                         out_illegal
);

    decoded_t              dec;
    decoded_t              main_q, main_d, skid_q, skid_d;
    logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic                  main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic                  accept, consume;

    id_decode u_decode (
        .instr_i (in_instruction),
        .dec_o   (dec)
    );

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign consume  = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        main_pc_d    = main_pc_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_pc_d    = skid_pc_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d    = dec;
                    main_pc_d = in_pc;
                end
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_pc_d    = in_pc;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments, and reset clears the data
    // registers too so every output reads as zero (type NONE) after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= DECODED_RESET;
            main_pc_q    <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= DECODED_RESET;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_pc_q    <= main_pc_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_pc_q;
    assign out_opcode  = main_q.opcode;
    assign out_type    = main_q.itype;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_imm     = XLEN'($signed(main_q.imm));
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a FIFO-level reference model checked every
// cycle, plus directed vectors with hand-computed expected values.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_type;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_illegal;

`ifdef ID_STAGE_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    id_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_type(out_type),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit [31:0] pc;
        bit [6:0]  opcode;
        int        typ;
        bit [4:0]  rd, rs1, rs2;
        bit [2:0]  funct3;
        bit [6:0]  funct7;
        bit [31:0] imm;
        bit        illegal;
    } exp_t;

    // Reference decode written from the format tables with integer arithmetic.
    function automatic exp_t model(input bit [31:0] inst, input bit [31:0] pc);
        exp_t e;
        int   si;
        bit [6:0] opc;
        si  = int'(inst);
        opc = inst[6:0];
        e.pc = pc;
        e.opcode = opc;
        case (opc)
            7'h33, 7'h2F:               e.typ = 0;
            7'h13, 7'h03, 7'h67, 7'h73: e.typ = 1;
            7'h23:                      e.typ = 2;
            7'h63:                      e.typ = 3;
            7'h37, 7'h17:               e.typ = 4;
            7'h6F:                      e.typ = 5;
            default:                    e.typ = 6;
        endcase
        e.rd     = (e.typ inside {0, 1, 4, 5}) ? inst[11:7]  : 5'd0;
        e.rs1    = (e.typ inside {0, 1, 2, 3}) ? inst[19:15] : 5'd0;
        e.rs2    = (e.typ inside {0, 2, 3})    ? inst[24:20] : 5'd0;
        e.funct3 = (e.typ <= 3)                ? inst[14:12] : 3'd0;
        e.funct7 = (e.typ == 0)                ? inst[31:25] : 7'd0;
        case (e.typ)
            1:       e.imm = si >>> 20;
            2:       e.imm = (si >>> 25) * 32 + int'(inst[11:7]);
            3:       e.imm = (si >>> 31) * 4096 + int'(inst[7]) * 2048 +
                             int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
            4:       e.imm = si & 32'hFFFF_F000;
            5:       e.imm = (si >>> 31) * (1 << 20) + int'(inst[19:12]) * 4096 +
                             int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
            default: e.imm = 0;
        endcase
        e.illegal = ILL_EN && ((e.typ == 6) || (inst[1:0] != 2'b11) ||
                    (opc == 7'h33 && !(inst[31:25] inside {7'h00, 7'h20, 7'h01})));
        return e;
    endfunction

    // The stage must behave as a 2-deep FIFO of decoded entries.
    exp_t mq[$];
    bit   cmp_en = 1'b0;

    always @(posedge clk) begin
        bit pop, push;
        pop  = (mq.size() > 0) && out_ready;
        push = in_valid && (mq.size() < 2);
        if (!rst_n || flush) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(model(in_instruction, in_pc));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_in_ready", in_ready, mq.size() < 2);
            check("cmp_out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0 && out_valid) begin
                check("cmp_pc", out_pc, mq[0].pc);
                check("cmp_opcode", out_opcode, mq[0].opcode);
                check("cmp_type", out_type, mq[0].typ);
                check("cmp_rd", out_rd, mq[0].rd);
                check("cmp_rs1", out_rs1, mq[0].rs1);
                check("cmp_rs2", out_rs2, mq[0].rs2);
                check("cmp_funct3", out_funct3, mq[0].funct3);
                check("cmp_funct7", out_funct7, mq[0].funct7);
                check("cmp_imm", out_imm, mq[0].imm);
                check("cmp_illegal", out_illegal, mq[0].illegal);
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit ordy, input bit fl = 1'b0);
        in_valid = v; in_instruction = inst; in_pc = pc; out_ready = ordy; flush = fl;
        @(negedge clk);
    endtask

    localparam logic [31:0] ADDI = 32'hFFF1_0093;

    logic [31:0] burst_inst [8] = '{32'h0000_0013, 32'hFE51_2C23, 32'h8000_00EF, 32'h0020_81B3,
                                    32'hFFFF_F537, 32'h0041_2283, 32'h0000_0000, 32'h7E00_0033};
    bit          burst_rdy  [8] = '{1, 0, 1, 1, 0, 0, 1, 1};

    initial begin
        logic [31:0] p;
        logic [31:0] seen [$];
        int          acc;
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cmp_en = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_type", out_type, 6);
        check("rst_pc", out_pc, 0);
        check("rst_imm", out_imm, 0);
        check("rst_illegal", out_illegal, 0);
        rst_n = 1'b1;

        // Single instructions and back-to-back throughput
        cyc(1, ADDI, 32'h100, 1);
        check("addi_valid", out_valid, 1);
        check("addi_type", out_type, 1);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 2);
        check("addi_funct3", out_funct3, 0);
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        check("addi_pc", out_pc, 32'h100);
        cyc(1, 32'hFE00_0EE3, 32'h104, 1);
        check("beq_type", out_type, 3);
        check("beq_rs1", out_rs1, 0);
        check("beq_rs2", out_rs2, 0);
        check("beq_rd", out_rd, 0);
        check("beq_imm", out_imm, 32'hFFFF_FFFC);
        cyc(1, 32'h1234_52B7, 32'h108, 1);
        check("lui_type", out_type, 4);
        check("lui_rd", out_rd, 5);
        check("lui_imm", out_imm, 32'h1234_5000);
        cyc(1, 32'h0000_006F, 32'h10C, 1);
        check("jal_valid", out_valid, 1);
        check("jal_type", out_type, 5);
        check("jal_imm", out_imm, 0);
        check("jal_pc", out_pc, 32'h10C);
        cyc(1, 32'hFE51_2C23, 32'h110, 1);
        check("sw_type", out_type, 2);
        check("sw_rs1", out_rs1, 2);
        check("sw_rs2", out_rs2, 5);
        check("sw_funct3", out_funct3, 2);
        check("sw_imm", out_imm, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 1);
        check("drain_valid", out_valid, 0);

        // Stall with in_valid held: only two entries accepted
        p = 0; acc = 0;
        repeat (3) begin
            bit a;
            a = in_ready;
            cyc(1, ADDI, p, 0);
            if (a) begin p += 4; acc++; end
        end
        check("stall_accepts", acc, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_pc", out_pc, 0);
        for (int i = 0; i < 5; i++) begin
            bit a;
            if (out_valid) seen.push_back(out_pc);
            a = in_ready;
            cyc(p <= 8, ADDI, p, 1);
            if (a && p <= 8) p += 4;
            if (i == 0) check("unstall_in_ready", in_ready, 1);
        end
        check("stall_count", seen.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < seen.size()) check($sformatf("stall_order%0d", i), seen[i], 32'(i * 4));

        // Flush with both entries full, then with an accept in the flush cycle
        cyc(1, ADDI, 32'h200, 0);
        cyc(1, ADDI, 32'h204, 0);
        check("full_in_ready", in_ready, 0);
        cyc(1, ADDI, 32'h208, 0, 1);
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        cyc(0, 0, 0, 1);
        check("flush_nothing", out_valid, 0);
        cyc(1, ADDI, 32'h300, 0);
        cyc(1, ADDI, 32'h304, 0, 1);
        check("flush_acc_valid", out_valid, 0);
        cyc(0, 0, 0, 1);
        check("flush_acc_gone", out_valid, 0);

        // Unknown and malformed encodings
        cyc(1, 32'h0000_0000, 32'h400, 1);
        check("none_type", out_type, 6);
        check("none_imm", out_imm, 0);
        check("none_illegal", out_illegal, ILL_EN);
        cyc(1, 32'h7E00_0033, 32'h404, 1);
        check("badf7_type", out_type, 0);
        check("badf7_illegal", out_illegal, ILL_EN);
        cyc(1, 32'h4000_0033, 32'h408, 1);
        check("sub_funct7", out_funct7, 7'h20);
        check("sub_illegal", out_illegal, 0);

        // Mixed burst under a backpressure pattern
        p = 32'h600;
        for (int i = 0, k = 0; i < 16 && k < 8; i++) begin
            bit a;
            a = in_ready;
            cyc(1, burst_inst[k], p, burst_rdy[i % 8]);
            if (a) begin p += 4; k++; end
        end
        repeat (4) cyc(0, 0, 0, 1);
        check("burst_drained", out_valid, 0);

        // Reset mid-stream
        cyc(1, ADDI, 32'h500, 0);
        cyc(1, 32'h1234_52B7, 32'h504, 0);
        rst_n = 1'b0;
        cyc(1, ADDI, 32'h508, 1);
        check("mrst_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_pc", out_pc, 0);
        check("mrst_imm", out_imm, 0);
        check("mrst_type", out_type, 6);
        check("mrst_rd", out_rd, 0);
        check("mrst_rs1", out_rs1, 0);
        check("mrst_opcode", out_opcode, 0);
        check("mrst_funct3", out_funct3, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1);
        check("post_rst_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
